// File: rtl/cpu_pkg.sv
// Shared definitions for the single-bus CPU datapath.
// XLEN is the architectural word width. word_t is the datapath word.
// PC_RST_VAL is the program counter value after reset.
package cpu_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    localparam word_t PC_RST_VAL = '0;

endpackage

// File: rtl/bus_tristate_drv.sv
// Tri-state driver that connects a register's stored value onto the shared
// datapath bus. Every bus-driving unit (PC, IR, GPRs, MDR) uses one of these.
// Ports:
//   en  : drive enable; when low, every bus bit is released to 'z'
//   d   : value to drive
//   bus : shared tri-state bus (w bits)
module bus_tristate_drv #(
    parameter int unsigned w = 32
) (
    input  logic         en,
    input  logic [w-1:0] d,
    output tri   [w-1:0] bus
);

    // Purely combinational enable, so the bus follows en in the same delta.
    assign bus = en ? d : {w{1'bz}};

endmodule

// File: rtl/pc_bus_reg.sv
// Program-counter register on the shared single-bus datapath.
// Loads the PC from the bus on a PCin strobe and drives it back onto the bus
// while PCout is high. There is no auto-increment: PC+4 is computed elsewhere
// and written back through PCin.
// Ports:
//   clk   : system clock, rising edge
//   rst   : asynchronous active-high reset, forces the PC to RST_VAL
//   bus   : shared tri-state datapath bus (w bits)
//   PCin  : load strobe, bus is captured at the next rising edge
//   PCout : output enable, drives the PC onto the bus while high
module pc_bus_reg
    import cpu_pkg::*;
#(
    parameter int unsigned  w       = XLEN,
    parameter logic [w-1:0] RST_VAL = w'(PC_RST_VAL)
) (
    input  logic         clk,
    input  logic         rst,
    inout  tri   [w-1:0] bus,
    input  logic         PCin,
    input  logic         PCout
);

    logic [w-1:0] pc_q;

    // PC register. The bus is only sampled at the edge, so PCin and PCout
    // together reload the driven value (a no-op) without a combinational loop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RST_VAL;
        end else if (PCin) begin
            pc_q <= bus;
        end
    end

    bus_tristate_drv #(
        .w (w)
    ) u_drv (
        .en  (PCout),
        .d   (pc_q),
        .bus (bus)
    );

    // While we drive, the bus must resolve to our value; anything else means
    // another unit is also driving.
    a_drive_clean: assert property (
        @(posedge clk) disable iff (rst)
        PCout |-> (!$isunknown(bus) && (bus == pc_q))
    );

    // Loading an unresolved bus means no unit drove it this cycle.
    a_load_known: assert property (
        @(posedge clk) disable iff (rst)
        PCin |-> !$isunknown(bus)
    );

endmodule

// File: tb/tb_pc_bus_reg.sv
// Scoreboard bench for pc_bus_reg: the stimulus pushes the expected bus value
// for each cycle in which something drives the bus, and a monitor pops and
// compares on every falling edge where the bus is driven.
module tb_pc_bus_reg;

    localparam int unsigned W = 32;
    localparam logic [W-1:0] RV = '0;

    typedef struct {
        string        name;
        logic [W-1:0] val;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         PCin;
    logic         PCout;
    logic         tb_en;
    logic [W-1:0] tb_val;
    wire  [W-1:0] bus;

    assign bus = tb_en ? tb_val : {W{1'bz}};

    pc_bus_reg #(
        .w       (W),
        .RST_VAL (RV)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .PCin  (PCin),
        .PCout (PCout)
    );

    // Clock starts high so each cycle opens with a falling (sample) edge.
    initial clk = 1'b1;
    always #5 clk = ~clk;

    exp_t         sb[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] model_pc;

    // Monitor: whenever the bus is driven by anyone, compare with the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (PCout || tb_en) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output: bus=%h with empty scoreboard", bus);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (bus !== e.val) begin
                        n_fail++;
                        $display("FAIL %s: bus=%h expected=%h", e.name, bus, e.val);
                    end
                end
            end
        end
    end

    // One bus cycle. Called just after a rising edge (or at start), returns
    // just after the next rising edge.
    // rmode: 0 = no reset, 1 = reset pulse that ends before the edge,
    //        2 = reset held across the edge.
    task automatic do_cycle(input int rmode, input logic pcin, input logic pcout,
                            input logic den, input logic [W-1:0] dval,
                            input string name);
        rst    = (rmode != 0);
        PCin   = pcin;
        PCout  = pcout;
        tb_en  = den;
        tb_val = dval;
        if (rmode != 0) model_pc = RV;
        if (pcout) sb.push_back('{name, model_pc});
        else if (den) sb.push_back('{{name, "_drv"}, dval});
        if (rmode == 1) begin
            @(negedge clk);
            #2;
            rst = 1'b0;
        end
        @(posedge clk);
        if (rmode == 2)            model_pc = RV;
        else if (pcin && !pcout)   model_pc = dval;
        #1;
    endtask

    initial begin
        rst = 1'b1; PCin = 1'b0; PCout = 1'b0; tb_en = 1'b0; tb_val = '0;
        model_pc = RV;
        #1;

        // Reset with PCout high and bus otherwise undriven.
        do_cycle(2, 1'b0, 1'b1, 1'b0, '0, "reset_state");

        // Load then read back.
        do_cycle(0, 1'b1, 1'b0, 1'b1, 32'h0000_000F, "load_f");
        do_cycle(0, 1'b0, 1'b1, 1'b0, '0, "read_f");

        // Hold while a foreign value sits on the bus.
        do_cycle(0, 1'b1, 1'b0, 1'b1, 32'h0000_0010, "load_10");
        for (int i = 0; i < 5; i++)
            do_cycle(0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, "hold_foreign");
        do_cycle(0, 1'b0, 1'b1, 1'b0, '0, "hold_read");

        // High-Z: with PCout low the bench's value must come through intact.
        do_cycle(0, 1'b0, 1'b0, 1'b1, 32'hA5A5_A5A5, "hiz_a");
        do_cycle(0, 1'b0, 1'b1, 1'b0, '0, "hiz_drive");
        do_cycle(0, 1'b0, 1'b0, 1'b1, 32'h5A5A_5A5A, "hiz_b");

        // Self-load with PCin and PCout both high.
        do_cycle(0, 1'b1, 1'b0, 1'b1, 32'h0000_0040, "load_40");
        for (int i = 0; i < 3; i++)
            do_cycle(0, 1'b1, 1'b1, 1'b0, '0, "self_load");
        do_cycle(0, 1'b0, 1'b1, 1'b0, '0, "self_load_after");

        // Asynchronous reset pulse between edges while PCin is high.
        do_cycle(0, 1'b1, 1'b0, 1'b1, 32'h1234_5678, "load_1234");
        do_cycle(0, 1'b0, 1'b1, 1'b0, '0, "read_1234");
        do_cycle(1, 1'b1, 1'b1, 1'b0, '0, "async_rst");
        do_cycle(0, 1'b0, 1'b1, 1'b0, '0, "after_rst");
        do_cycle(0, 1'b1, 1'b0, 1'b1, 32'hCAFE_F00D, "load_after_rst");
        do_cycle(0, 1'b0, 1'b1, 1'b0, '0, "read_after_rst");

        // Reset held across an edge wins over PCin.
        do_cycle(2, 1'b1, 1'b0, 1'b1, 32'h0000_0077, "rst_prio");
        do_cycle(0, 1'b0, 1'b1, 1'b0, '0, "rst_prio_read");

        // Randomized traffic honouring single-driver bus rules.
        for (int i = 0; i < 300; i++) begin
            logic         pcout;
            logic         den;
            logic         pcin;
            int           rmode;
            int           r;
            logic [W-1:0] v;
            pcout = 1'($urandom_range(0, 1));
            den   = pcout ? 1'b0 : 1'(($urandom_range(0, 3)) != 0);
            pcin  = (pcout || den) ? 1'($urandom_range(0, 1)) : 1'b0;
            r     = int'($urandom_range(0, 19));
            rmode = (r == 0) ? 1 : ((r == 1) ? 2 : 0);
            v     = W'($urandom());
            do_cycle(rmode, pcin, pcout, den, v, "random");
        end

        PCout = 1'b0; PCin = 1'b0; tb_en = 1'b0; rst = 1'b0;
        @(posedge clk);
        @(posedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
